// File: rtl/bcd_counter_n_pkg.sv
// Shared BCD definitions for the multi-digit decimal counter.
// Provides the digit width and maximum, plus elaboration-time helpers
// for packing an integer as BCD and for clamping a nibble to 9.
package bcd_pkg;

  localparam int         BCD_W   = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam int         MAX_DIGITS = 8;

  // Packs an integer into up to eight BCD digits, least significant digit in [3:0].
  function automatic logic [4*MAX_DIGITS-1:0] int_to_bcd(input int unsigned value);
    logic [4*MAX_DIGITS-1:0] res;
    int unsigned v;
    res = '0;
    v   = value;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      res[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return res;
  endfunction

  // Replaces any non-decimal nibble with 9 so the counter never holds an illegal digit.
  function automatic logic [3:0] clamp9(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_counter_n_if.sv
// Control and status bundle of the BCD counter.
// The master side (user logic or bench) drives the controls and load value;
// the slave side (the counter) returns the count and status flags.
interface bcd_counter_n_if #(
  parameter int NDIGITS = 4
);

  logic                   en;
  logic                   up;
  logic                   clr;
  logic                   load;
  logic [4*NDIGITS-1:0]   load_val;
  logic [4*NDIGITS-1:0]   cnt;
  logic                   tc;
  logic                   cout;
  logic                   ovf;
  logic                   load_err;

  modport master (
    output en, up, clr, load, load_val,
    input  cnt, tc, cout, ovf, load_err
  );

  modport slave (
    input  en, up, clr, load, load_val,
    output cnt, tc, cout, ovf, load_err
  );

endinterface

// File: rtl/bcd_counter_n_digit.sv
// One decimal digit of the cascaded counter.
// Steps up or down by one when step is high, wrapping 9->0 or 0->9;
// clear and load take priority over stepping. Flags report 9 and 0
// so the parent can build the carry/borrow chain.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic [3:0] rst_val,
  input  logic       clr,
  input  logic       load,
  input  logic [3:0] load_d,
  input  logic       step,
  input  logic       up,
  output logic [3:0] digit,
  output logic       is_max,
  output logic       is_min
);

  logic [3:0] digit_q;

  // Digit register: reset/clear to the reset digit, load clamps, otherwise step with wrap.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      digit_q <= rst_val;
    end else if (clr) begin
      digit_q <= rst_val;
    end else if (load) begin
      digit_q <= clamp9(load_d);
    end else if (step) begin
      if (up) begin
        digit_q <= (digit_q == BCD_MAX) ? 4'd0 : digit_q + 4'd1;
      end else begin
        digit_q <= (digit_q == 4'd0) ? BCD_MAX : digit_q - 4'd1;
      end
    end
  end

  assign digit  = digit_q;
  assign is_max = (digit_q == BCD_MAX);
  assign is_min = (digit_q == 4'd0);

endmodule

// File: rtl/bcd_counter_n.sv
// Parametrised N-digit BCD up/down counter with clear, parallel load,
// combinational terminal count / carry out and a sticky overflow flag.
// Optional macro BCD_CNT_SAT_EN: saturate at all-9 / all-0 instead of wrapping
// (overflow still flags the blocked step).
module bcd_counter_n
  import bcd_pkg::*;
#(
  parameter int NDIGITS = 4,
  parameter int RST_VAL = 0
) (
  input  logic            clk,
  input  logic            rstn,
  bcd_counter_n_if.slave  bus
);

  localparam int W = BCD_W * NDIGITS;
  localparam logic [4*MAX_DIGITS-1:0] RST_BCD_ALL = int_to_bcd(RST_VAL);
  localparam logic [W-1:0]            RST_BCD     = RST_BCD_ALL[W-1:0];

  logic [NDIGITS-1:0] is_max;
  logic [NDIGITS-1:0] is_min;
  logic [NDIGITS-1:0] step;
  logic [NDIGITS-1:0] bad_digit;
  logic [W-1:0]       cnt;
  logic               all_max;
  logic               all_min;
  logic               tc;
  logic               cout;
  logic               blocked;
  logic               ovf_q;
  logic               load_err_q;

  assign all_max = &is_max;
  assign all_min = &is_min;
  assign tc      = bus.up ? all_max : all_min;
  assign cout    = tc & bus.en;

`ifdef BCD_CNT_SAT_EN
  assign blocked = tc;
`else
  assign blocked = 1'b0;
`endif

  // Each digit steps when enabled and every lower digit is at its carry/borrow value.
  for (genvar i = 0; i < NDIGITS; i++) begin : g_digit
    if (i == 0) begin : g_first
      assign step[i] = bus.en & ~blocked;
    end else begin : g_rest
      assign step[i] = bus.en & ~blocked &
                       (bus.up ? (&is_max[i-1:0]) : (&is_min[i-1:0]));
    end

    assign bad_digit[i] = (bus.load_val[4*i +: 4] > BCD_MAX);

    bcd_digit u_digit (
      .clk     (clk),
      .rstn    (rstn),
      .rst_val (RST_BCD[4*i +: 4]),
      .clr     (bus.clr),
      .load    (bus.load),
      .load_d  (bus.load_val[4*i +: 4]),
      .step    (step[i]),
      .up      (bus.up),
      .digit   (cnt[4*i +: 4]),
      .is_max  (is_max[i]),
      .is_min  (is_min[i])
    );
  end

  // Status flags: sticky overflow on any wrap (or blocked step), one-cycle load error.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf_q      <= 1'b0;
      load_err_q <= 1'b0;
    end else if (bus.clr) begin
      ovf_q      <= 1'b0;
      load_err_q <= 1'b0;
    end else if (bus.load) begin
      load_err_q <= |bad_digit;
    end else begin
      load_err_q <= 1'b0;
      if (cout) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign bus.cnt      = cnt;
  assign bus.tc       = tc;
  assign bus.cout     = cout;
  assign bus.ovf      = ovf_q;
  assign bus.load_err = load_err_q;

endmodule

// File: tb/tb_bcd_counter_n.sv
// Scoreboard bench for the 3-digit BCD counter (RST_VAL = 0).
// Each stimulus pushes its expected response; a monitor pops it, checks the
// pre-edge combinational flags on the falling edge and the registered state
// just after the next rising edge.
module tb_bcd_counter_n;

  localparam int NDIGITS = 3;
`ifdef BCD_CNT_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    int          id;
    logic        tc;
    logic        cout;
    logic [11:0] cnt;
    logic        ovf;
    logic        lerr;
  } exp_t;

  logic clk;
  logic rstn;
  int   vec_count;
  int   miscompares;
  int   next_id;
  exp_t exp_q[$];

  bcd_counter_n_if #(.NDIGITS(NDIGITS)) bus ();

  bcd_counter_n #(.NDIGITS(NDIGITS), .RST_VAL(0)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [11:0] actual, input logic [11:0] expected);
    vec_count++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic up, input logic clr, input logic load,
                               input logic [11:0] val, input logic e_tc, input logic e_cout,
                               input logic [11:0] e_cnt, input logic e_ovf, input logic e_lerr);
    exp_t e;
    @(posedge clk);
    #2;
    bus.en       = en;
    bus.up       = up;
    bus.clr      = clr;
    bus.load     = load;
    bus.load_val = val;
    e.id   = next_id;
    e.tc   = e_tc;
    e.cout = e_cout;
    e.cnt  = e_cnt;
    e.ovf  = e_ovf;
    e.lerr = e_lerr;
    next_id++;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      vec_count++;
      miscompares++;
      $display("[TB] FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    @(posedge clk);
    #2;
  endtask

  // Monitor: pre-edge flags at the falling edge, post-edge state after the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput($sformatf("v%0d tc", e.id), {11'd0, bus.tc}, {11'd0, e.tc});
        checkOutput($sformatf("v%0d cout", e.id), {11'd0, bus.cout}, {11'd0, e.cout});
        @(posedge clk);
        #1;
        checkOutput($sformatf("v%0d cnt", e.id), bus.cnt, e.cnt);
        checkOutput($sformatf("v%0d ovf", e.id), {11'd0, bus.ovf}, {11'd0, e.ovf});
        checkOutput($sformatf("v%0d load_err", e.id), {11'd0, bus.load_err}, {11'd0, e.lerr});
      end
    end
  end

  initial begin
    vec_count    = 0;
    miscompares  = 0;
    next_id      = 0;
    rstn         = 1'b0;
    bus.en       = 1'b0;
    bus.up       = 1'b1;
    bus.clr      = 1'b0;
    bus.load     = 1'b0;
    bus.load_val = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;

    checkOutput("reset cnt", bus.cnt, 12'h000);
    checkOutput("reset ovf", {11'd0, bus.ovf}, 12'h000);
    checkOutput("reset load_err", {11'd0, bus.load_err}, 12'h000);
    checkOutput("reset tc", {11'd0, bus.tc}, 12'h000);

    // Idle hold, then load 123 and pull reset asynchronously.
    repeat (5) applyStimulus(0, 1, 0, 0, 12'h000, 0, 0, 12'h000, 0, 0);
    applyStimulus(0, 1, 0, 1, 12'h123, 0, 0, 12'h123, 0, 0);
    drain();
    rstn = 1'b0;
    #1;
    checkOutput("async reset cnt", bus.cnt, 12'h000);
    checkOutput("async reset ovf", {11'd0, bus.ovf}, 12'h000);
    @(negedge clk);
    rstn = 1'b1;

    // Up count through the wrap, then carry ripple checks.
    applyStimulus(0, 1, 0, 1, 12'h998, 0, 0, 12'h998, 0, 0);
    applyStimulus(1, 1, 0, 0, 12'h000, 0, 0, 12'h999, 0, 0);
    applyStimulus(1, 1, 0, 0, 12'h000, 1, 1, SAT ? 12'h999 : 12'h000, 1, 0);
    applyStimulus(0, 1, 0, 1, 12'h089, SAT ? 1'b1 : 1'b0, 0, 12'h089, 1, 0);
    applyStimulus(1, 1, 0, 0, 12'h000, 0, 0, 12'h090, 1, 0);
    applyStimulus(0, 1, 0, 1, 12'h099, 0, 0, 12'h099, 1, 0);
    applyStimulus(1, 1, 0, 0, 12'h000, 0, 0, 12'h100, 1, 0);

    // Clear, then down count through the borrow wrap.
    applyStimulus(0, 0, 1, 0, 12'h000, 0, 0, 12'h000, 0, 0);
    applyStimulus(1, 0, 0, 0, 12'h000, 1, 1, SAT ? 12'h000 : 12'h999, 1, 0);
    applyStimulus(1, 0, 0, 0, 12'h000, SAT ? 1'b1 : 1'b0, SAT ? 1'b1 : 1'b0,
                  SAT ? 12'h000 : 12'h998, 1, 0);

    // Non-BCD load clamps and flags for exactly one cycle.
    applyStimulus(0, 1, 0, 1, 12'h3A7, 0, 0, 12'h397, 1, 1);
    applyStimulus(0, 1, 0, 0, 12'h000, 0, 0, 12'h397, 1, 0);
    applyStimulus(0, 1, 0, 1, 12'h250, 0, 0, 12'h250, 1, 0);

    // Priority: clear beats load and enable; load beats enable.
    applyStimulus(1, 1, 1, 1, 12'h555, 0, 0, 12'h000, 0, 0);
    applyStimulus(1, 1, 0, 1, 12'h555, 0, 0, 12'h555, 0, 0);
    applyStimulus(0, 1, 0, 1, 12'hFFF, 0, 0, 12'h999, 0, 1);

    // Three enabled up steps from all-9, then a direction change on the fly.
    applyStimulus(1, 1, 0, 0, 12'h000, 1, 1, SAT ? 12'h999 : 12'h000, 1, 0);
    applyStimulus(1, 1, 0, 0, 12'h000, SAT ? 1'b1 : 1'b0, SAT ? 1'b1 : 1'b0,
                  SAT ? 12'h999 : 12'h001, 1, 0);
    applyStimulus(1, 1, 0, 0, 12'h000, SAT ? 1'b1 : 1'b0, SAT ? 1'b1 : 1'b0,
                  SAT ? 12'h999 : 12'h002, 1, 0);
    applyStimulus(1, 0, 0, 0, 12'h000, 0, 0, SAT ? 12'h998 : 12'h001, 1, 0);
    applyStimulus(1, 1, 0, 0, 12'h000, 0, 0, SAT ? 12'h999 : 12'h002, 1, 0);
    applyStimulus(0, 1, 0, 0, 12'h000, SAT ? 1'b1 : 1'b0, 0, SAT ? 12'h999 : 12'h002, 1, 0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
